// File: rtl/chiplet_vc_link.sv
// Multi-VC credit-based chiplet link: round-robin arbiter, one registered link stage,
// per-VC RX FIFOs with registered credit return and a sticky overflow flag.
module chiplet_vc_link #(
  parameter int unsigned FLIT_WIDTH      = 40,
  parameter int unsigned NUM_VC          = 2,
  parameter int unsigned FIFO_DEPTH      = 32,
  parameter int unsigned LOG2_FIFO_DEPTH = 5,
  parameter int unsigned VC_W            = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_VC*FLIT_WIDTH-1:0]           i_tx_flit,
  input  logic [NUM_VC-1:0]                      i_tx_valid,
  output logic [NUM_VC-1:0]                      o_tx_ready,
  output logic [NUM_VC*FLIT_WIDTH-1:0]           o_rx_flit,
  output logic [NUM_VC-1:0]                      o_rx_valid,
  input  logic [NUM_VC-1:0]                      i_rx_ready,
  output logic [NUM_VC*(LOG2_FIFO_DEPTH+1)-1:0]  o_credits,
  output logic                                   o_overflow_err
);

  localparam int unsigned CW = LOG2_FIFO_DEPTH + 1;
  localparam int unsigned PW = LOG2_FIFO_DEPTH;

  logic [CW-1:0]         cred   [NUM_VC];
  logic [CW-1:0]         cnt    [NUM_VC];
  logic [PW-1:0]         wr_ptr [NUM_VC];
  logic [PW-1:0]         rd_ptr [NUM_VC];
  logic [FLIT_WIDTH-1:0] mem    [NUM_VC][FIFO_DEPTH];
  logic [NUM_VC-1:0]     cret;
  logic [VC_W-1:0]       rr_ptr;
  logic                  lnk_valid;
  logic [VC_W-1:0]       lnk_vc;
  logic [FLIT_WIDTH-1:0] lnk_flit;

  logic                  gnt_any;
  logic [VC_W-1:0]       gnt_vc;
  logic [FLIT_WIDTH-1:0] gnt_flit;
  logic [NUM_VC-1:0]     elig;
  logic [NUM_VC-1:0]     accept;
  logic [NUM_VC-1:0]     pop;
  logic [NUM_VC-1:0]     wr_en;
  logic [NUM_VC-1:0]     full;
  logic                  ovf_hit;

  // Round-robin: first eligible VC at or above rr_ptr, else first eligible below it
  always_comb begin
    gnt_any  = 1'b0;
    gnt_vc   = '0;
    gnt_flit = '0;
    elig     = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      elig[v] = i_tx_valid[v] && (cred[v] != '0);
    end
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (!gnt_any && elig[v] && (VC_W'(v) >= rr_ptr)) begin
        gnt_any = 1'b1;
        gnt_vc  = VC_W'(v);
      end
    end
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (!gnt_any && elig[v] && (VC_W'(v) < rr_ptr)) begin
        gnt_any = 1'b1;
        gnt_vc  = VC_W'(v);
      end
    end
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (gnt_vc == VC_W'(v)) begin
        gnt_flit = i_tx_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  // Per-VC handshakes and output decode
  always_comb begin
    o_tx_ready = '0;
    accept     = '0;
    pop        = '0;
    wr_en      = '0;
    full       = '0;
    ovf_hit    = 1'b0;
    o_rx_valid = '0;
    o_rx_flit  = '0;
    o_credits  = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      o_tx_ready[v] = rst_n && gnt_any && (gnt_vc == VC_W'(v));
      accept[v]     = i_tx_valid[v] && o_tx_ready[v];
      full[v]       = (cnt[v] == CW'(FIFO_DEPTH));
      o_rx_valid[v] = (cnt[v] != '0);
      pop[v]        = o_rx_valid[v] && i_rx_ready[v];
      wr_en[v]      = lnk_valid && (lnk_vc == VC_W'(v)) && !full[v];
      ovf_hit       = ovf_hit || (lnk_valid && (lnk_vc == VC_W'(v)) && full[v]);
      if (o_rx_valid[v]) begin
        o_rx_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = mem[v][rd_ptr[v]];
      end
      o_credits[v*CW +: CW] = cred[v];
    end
  end

  // Link stage and arbiter pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lnk_valid <= 1'b0;
      lnk_vc    <= '0;
      lnk_flit  <= '0;
      rr_ptr    <= '0;
    end else begin
      lnk_valid <= |accept;
      if (|accept) begin
        lnk_vc   <= gnt_vc;
        lnk_flit <= gnt_flit;
        rr_ptr   <= (gnt_vc == VC_W'(NUM_VC - 1)) ? '0 : gnt_vc + VC_W'(1);
      end
    end
  end

  // Credits, credit return, FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cret           <= '0;
      o_overflow_err <= 1'b0;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        cred[v]   <= CW'(FIFO_DEPTH);
        cnt[v]    <= '0;
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
      end
    end else begin
      cret <= pop;
      if (ovf_hit) o_overflow_err <= 1'b1;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (accept[v] && !cret[v])      cred[v] <= cred[v] - CW'(1);
        else if (!accept[v] && cret[v]) cred[v] <= cred[v] + CW'(1);
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (pop[v])   rd_ptr[v] <= rd_ptr[v] + PW'(1);
        if (wr_en[v] && !pop[v])      cnt[v] <= cnt[v] + CW'(1);
        else if (!wr_en[v] && pop[v]) cnt[v] <= cnt[v] - CW'(1);
      end
    end
  end

  // FIFO storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v]] <= lnk_flit;
    end
  end

endmodule

// File: tb/tb_chiplet_vc_link.sv
// Self-checking bench for chiplet_vc_link: directed scenarios plus random soak,
// all outputs compared every cycle against a queue-based reference model.
module tb_chiplet_vc_link;

  localparam int FW = 40;
  localparam int NV = 2;
  localparam int D  = 32;
  localparam int LD = 5;
  localparam int CW = LD + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NV*FW-1:0]  tx_flit;
  logic [NV-1:0]     tx_valid;
  logic [NV-1:0]     tx_ready;
  logic [NV*FW-1:0]  rx_flit;
  logic [NV-1:0]     rx_valid;
  logic [NV-1:0]     rx_ready;
  logic [NV*CW-1:0]  credits;
  logic              ovf;

  always #5 clk = ~clk;

  chiplet_vc_link #(
    .FLIT_WIDTH(FW), .NUM_VC(NV), .FIFO_DEPTH(D), .LOG2_FIFO_DEPTH(LD), .VC_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_tx_flit(tx_flit), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_flit(rx_flit), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_credits(credits), .o_overflow_err(ovf)
  );

  // Reference model: credits as integers, RX FIFOs as queues, one in-flight slot
  logic [FW-1:0] q [NV][$];
  int            m_cred [NV];
  bit            m_cret [NV];
  int            m_rr;
  bit            m_lv;
  int            m_lvc;
  logic [FW-1:0] m_lflit;
  bit            m_ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc;
  bit obs_pop [NV];
  logic [FW-1:0] popped [NV][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int cr(input int v);
    return int'(credits[v*CW +: CW]);
  endfunction

  function automatic int m_grant();
    for (int i = 0; i < NV; i++) begin
      int v;
      v = (m_rr + i) % NV;
      if (tx_valid[v] && m_cred[v] > 0) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      q[v].delete();
      m_cred[v] = D;
      m_cret[v] = 1'b0;
    end
    m_rr = 0; m_lv = 1'b0; m_lvc = 0; m_lflit = '0; m_ovf = 1'b0;
  endtask

  // Inputs already driven at the negedge; compare, clock once, advance the model
  task automatic step(input bit rst);
    int g;
    bit mpop [NV];
    bit wr;
    rst_n = !rst;
    #1;
    g = rst ? -1 : m_grant();
    for (int v = 0; v < NV; v++) begin
      check("tx_ready", 64'(tx_ready[v]), 64'(g == v));
      check("credits", 64'(cr(v)), 64'(m_cred[v]));
      check("rx_valid", 64'(rx_valid[v]), 64'(q[v].size() > 0));
      check("rx_flit", 64'(rx_flit[v*FW +: FW]), (q[v].size() > 0) ? 64'(q[v][0]) : 64'd0);
    end
    check("overflow", 64'(ovf), 64'(m_ovf));
    last_acc = -1;
    for (int v = 0; v < NV; v++) begin
      if (tx_valid[v] && tx_ready[v]) last_acc = v;
      obs_pop[v] = rx_valid[v] && rx_ready[v];
      if (obs_pop[v]) popped[v].push_back(rx_flit[v*FW +: FW]);
      mpop[v] = rx_ready[v] && (q[v].size() > 0);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      for (int v = 0; v < NV; v++) begin
        m_cred[v] = m_cred[v] + (m_cret[v] ? 1 : 0) - ((g == v) ? 1 : 0);
        m_cret[v] = mpop[v];
      end
      wr = m_lv;
      if (wr && q[m_lvc].size() >= D) begin
        m_ovf = 1'b1;
        wr = 1'b0;
      end
      for (int v = 0; v < NV; v++) if (mpop[v]) void'(q[v].pop_front());
      if (wr) q[m_lvc].push_back(m_lflit);
      m_lv = (g >= 0);
      if (g >= 0) begin
        m_lvc   = g;
        m_lflit = tx_flit[g*FW +: FW];
        m_rr    = (g + 1) % NV;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    tx_valid = '0;
    rx_ready = '0;
    step(1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, first_pop, first_acc;
    tx_flit = '0; tx_valid = '0; rx_ready = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state
    for (int v = 0; v < NV; v++) begin
      check("rst_cred", 64'(cr(v)), 64'(D));
      check("rst_rx_valid", 64'(rx_valid[v]), 64'd0);
      check("rst_rx_flit", 64'(rx_flit[v*FW +: FW]), 64'd0);
    end
    check("rst_ovf", 64'(ovf), 64'd0);

    // Single flit after reset
    do_reset();
    rx_ready = '1;
    tx_valid = 2'b01;
    tx_flit[FW-1:0] = 40'h12_3456_789A;
    step(1'b0);
    check("single_acc", 64'(last_acc), 64'd0);
    check("single_cred31", 64'(cr(0)), 64'd31);
    tx_valid = '0;
    step(1'b0);
    check("single_rx_valid", 64'(rx_valid[0]), 64'd1);
    check("single_rx_flit", 64'(rx_flit[FW-1:0]), 64'h12_3456_789A);
    step(1'b0);
    check("single_cred_pop", 64'(cr(0)), 64'd31);
    step(1'b0);
    check("single_cred32", 64'(cr(0)), 64'd32);

    // Fairness: both VCs valid, alternating grants from VC0
    do_reset();
    rx_ready = '1;
    tx_valid = '1;
    for (int i = 0; i < 8; i++) begin
      tx_flit = {FW'(200 + i), FW'(100 + i)};
      step(1'b0);
      check("fair_order", 64'(last_acc), 64'(i % 2));
    end

    // Saturation of VC1 with VC0 still flowing
    do_reset();
    rx_ready = 2'b01;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 200 && n1 < 32; i++) begin
      tx_valid = {1'b1, 1'($urandom_range(0, 1))};
      tx_flit  = {FW'(32'h100 + n1), FW'($urandom())};
      step(1'b0);
      if (last_acc == 1) n1++;
      if (last_acc == 0) n0++;
    end
    check("sat_accepts", 64'(n1), 64'd32);
    check("sat_cred0", 64'(cr(1)), 64'd0);
    check("sat_vc0_flow", 64'(n0 > 0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tx_valid = 2'b11;
      tx_flit  = {FW'(32'h100 + n1), FW'($urandom())};
      step(1'b0);
      check("sat_no_vc1_acc", 64'(last_acc == 1), 64'd0);
    end
    tx_valid = 2'b10;
    rx_ready = 2'b11;
    popped[1].delete();
    first_pop = -1; first_acc = -1;
    for (int i = 0; i < 60; i++) begin
      tx_flit = {FW'(32'h100 + n1), FW'(0)};
      step(1'b0);
      if (obs_pop[1] && first_pop < 0) first_pop = cyc;
      if (last_acc == 1) begin
        if (first_acc < 0) first_acc = cyc;
        n1++;
      end
    end
    check("sat_reaccept_gap", 64'(first_acc - first_pop), 64'd2);
    check("sat_pop_count", 64'(popped[1].size() >= 32), 64'd1);
    for (int i = 0; i < 32 && i < popped[1].size(); i++) begin
      check("sat_pop_order", 64'(popped[1][i]), 64'(32'h100 + i));
    end

    // Simultaneous accept and credit return at credit 1
    do_reset();
    tx_valid = 2'b01;
    for (int i = 0; i < 31; i++) begin
      tx_flit = {FW'(0), FW'(i)};
      step(1'b0);
    end
    tx_valid = '0;
    step(1'b0);
    step(1'b0);
    check("simul_cred1", 64'(cr(0)), 64'd1);
    rx_ready = 2'b01;
    step(1'b0);
    rx_ready = '0;
    tx_valid = 2'b01;
    step(1'b0);
    check("simul_acc", 64'(last_acc), 64'd0);
    check("simul_cred_hold", 64'(cr(0)), 64'd1);
    tx_valid = '0;
    step(1'b0);
    check("simul_cred_after", 64'(cr(0)), 64'd1);

    // Reset with 10 flits buffered and one in the link stage
    do_reset();
    tx_valid = 2'b01;
    for (int i = 0; i < 11; i++) begin
      tx_flit = {FW'(0), FW'(32'h500 + i)};
      step(1'b0);
    end
    check("mid_buffered", 64'(rx_valid[0]), 64'd1);
    tx_valid = '0;
    step(1'b1);
    for (int v = 0; v < NV; v++) check("mid_cred", 64'(cr(v)), 64'(D));
    check("mid_rx_valid", 64'(rx_valid), 64'd0);
    check("mid_ovf", 64'(ovf), 64'd0);
    rx_ready = '1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check("mid_no_ghost", 64'(rx_valid), 64'd0);
    end

    // Random soak with phased consumer back-pressure
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 60 : 95);
      for (int v = 0; v < NV; v++) begin
        tx_valid[v] = ($urandom_range(0, 99) < 70);
        rx_ready[v] = ($urandom_range(0, 99) < rdy_pct);
        tx_flit[v*FW +: FW] = FW'({$urandom(), $urandom()});
      end
      step(1'b0);
      for (int v = 0; v < NV; v++) begin
        check("soak_conserve",
              64'(cr(v) + q[v].size() + ((m_lv && m_lvc == v) ? 1 : 0) + (m_cret[v] ? 1 : 0)),
              64'(D));
      end
    end
    check("soak_ovf", 64'(ovf), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chiplet_vc_link.md
# chiplet_vc_link

Parametrised successor to the single-channel strawman chiplet link. Carries flits from a TX chiplet to an RX chiplet over `NUM_VC` independent virtual channels. Each channel has its own receive FIFO, a real credit counter and a credit-return path. A round-robin arbiter shares one registered link stage among the channels. It sits between the strawman TX FSM (flit producer) and the RX FSM (flit consumer), replacing the fixed-depth FIFO pair with constant credit wires.

## Interface
- `FLIT_WIDTH`, 40: flit width in bits.
- `NUM_VC`, 2: number of virtual channels (1..8).
- `FIFO_DEPTH`, 32: RX FIFO entries per VC; also the initial credit count.
- `LOG2_FIFO_DEPTH`, 5: log2(FIFO_DEPTH); credit counters are LOG2_FIFO_DEPTH+1 bits.
- `VC_W`, 3: width of the internal VC index.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_tx_flit`  in  NUM_VC*FLIT_WIDTH  per-VC flit; VC v is at [v*FLIT_WIDTH +: FLIT_WIDTH].
- `i_tx_valid`  in  NUM_VC  per-VC flit valid.
- `o_tx_ready`  out  NUM_VC  per-VC accept. One-hot or zero.
- `o_rx_flit`  out  NUM_VC*FLIT_WIDTH  per-VC FIFO head. Zero when that FIFO is empty.
- `o_rx_valid`  out  NUM_VC  per-VC FIFO non-empty.
- `i_rx_ready`  in  NUM_VC  per-VC consumer pop request.
- `o_credits`  out  NUM_VC*(LOG2_FIFO_DEPTH+1)  per-VC TX credit counter, for observability.
- `o_overflow_err`  out  1  sticky flag: a write hit a full FIFO.

## Operation
- **Credits**
  - Counter `cred[v]` resets to FIFO_DEPTH.
  - Decrements by 1 on a TX accept for v.
  - Increments by 1 when `cret[v]` (registered credit return) is set.
  - Both in the same cycle: net unchanged.
  - Range is [0, FIFO_DEPTH]. No wrap is permitted.
- **Arbiter**
  - Eligible VC: `i_tx_valid[v] && cred[v] != 0`.
  - Search starts at `rr_ptr` and goes upward, wrapping modulo NUM_VC. The first eligible VC gets the grant.
  - `o_tx_ready[v]` is 1 only for the granted VC. It is combinational on `i_tx_valid` and `cred`.
  - Accept is `i_tx_valid[v] & o_tx_ready[v]`.
  - On accept, `rr_ptr` becomes (v+1) mod NUM_VC. With no accept it holds.
- **Link stage**
  - On accept, `lnk_valid`, `lnk_vc` and `lnk_flit` are registered.
  - With no accept, `lnk_valid` clears on the next edge.
- **RX FIFO**
  - Write: `lnk_valid` writes `lnk_flit` into FIFO[`lnk_vc`].
  - Pop: `o_rx_valid[v] & i_rx_ready[v]` removes the head.
  - Write and pop in the same cycle on one FIFO are both performed; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order within a VC is preserved. There is no ordering guarantee across VCs.
- **Credit return**: each pop sets `cret[v]` for one cycle. Credits are per-VC and independent; a full VC never blocks another.
- **Error**: a write to a full FIFO is dropped and sets `o_overflow_err`, which holds until reset. This must never happen with correct credits.
- **Reset** (`rst_n` low at an edge), including mid-operation:
  - Cleared state: credits = FIFO_DEPTH, FIFOs empty, `lnk_valid` = 0, `cret` = 0, `rr_ptr` = 0, `o_overflow_err` = 0.
  - In-flight and buffered flits are discarded.
  - While `rst_n` is low, `o_tx_ready` is forced to 0.
  - Output values after reset: `o_rx_valid` = 0, `o_rx_flit` = 0, `o_credits` = FIFO_DEPTH per VC.

## Timing
- **Data latency**: accept at edge E → `lnk_valid` during cycle E..E+1 → FIFO write at E+1 → `o_rx_valid` high after E+1. That is 2 cycles, accept edge to RX visibility.
- **Credit loop**: pop at edge P → `cret` set after P → `cred` increments at P+1 → new accept possible at P+2 edge at the earliest. Round trip is accept, then 2 cycles to RX, then the pop, then 2 cycles back. FIFO_DEPTH ≥ 4 sustains full rate on one VC.
- **Throughput**: at most 1 flit per cycle total across all VCs, and 1 pop per VC per cycle.

## Test plan
- **Single flit after reset**: VC0 valid with flit 0x12_3456_789A for 1 cycle, `i_rx_ready` = 1.
  - Accepted at edge E; `o_credits`[0] = 31 after E.
  - `o_rx_valid[0]` with the same flit after E+1.
  - Credit back to 32 two edges after the pop.
- **Saturation**: VC1 held valid with incrementing flits, `i_rx_ready[1]` = 0.
  - Exactly 32 accepts, then `o_tx_ready[1]` = 0 and `o_credits`[1] = 0.
  - VC0 traffic still flows during this.
  - Raise `i_rx_ready[1]`: flits pop in order 0..31, and the first new VC1 accept occurs 2 edges after the first pop.
- **Fairness**: both VCs continuously valid, ample credits. Grants alternate 0,1,0,1 starting from VC0 after reset. With NUM_VC = 4 and all valid, the order is 0,1,2,3,0.
- **Simultaneous update**: VC0 at credit 1, with an accept and a `cret[0]` in the same cycle. `o_credits`[0] stays 1 and never reaches 0 or wraps.
- **Reset mid-traffic**: `rst_n` low for 1 edge while 10 flits are buffered and one is in the link stage.
  - Next cycle: all `o_rx_valid` = 0, credits = 32, `o_overflow_err` = 0.
  - The in-flight flit never appears.
- **Random soak**: 10k cycles of random valid/ready on all VCs. Per-VC order is preserved, `o_overflow_err` stays 0, and `cred[v]` + FIFO count + in-flight count equals FIFO_DEPTH every cycle.
